// File: rtl/alu_exec.sv
// Registered ALU execute stage: AND/OR/ADD/SUB with a zero flag, buffered by a
// main + skid register pair so in_ready stays a pure register output.
module alu_exec #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic            out_illegal
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic            accept, pop;
  logic [XLEN-1:0] res_p0;
  logic            ill_p0, zero_p0;
  logic [XLEN-1:0] main_res_p1, skid_res_p1;
  logic            main_zero_p1, skid_zero_p1;
  logic            main_ill_p1, skid_ill_p1;
  logic            load_main, load_skid, move_skid;

  // Returns {illegal, result}; unknown or unsupported codes yield an illegal zero result.
  function automatic logic [XLEN:0] alu_eval(input logic [3:0] op,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    logic [XLEN-1:0] one;
    one = {{(XLEN-1){1'b0}}, 1'b1};
    case (op)
      4'b0000: alu_eval = {1'b0, a & b};
      4'b0001: alu_eval = {1'b0, a | b};
      4'b0010: alu_eval = {1'b0, a + b};
      4'b0110: alu_eval = {1'b0, a + ~b + one};
      default: alu_eval = {1'b1, {XLEN{1'b0}}};
    endcase
  endfunction

  // Stage p0: combinational evaluation of the offered operation
  always_comb begin
    {ill_p0, res_p0} = alu_eval(alu_op, operand_a, operand_b);
    zero_p0          = (res_p0 == '0);
  end

  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign load_main = (state == EMPTY && accept) || (state == ONE && accept && pop);
  assign load_skid = (state == ONE) && accept && !pop;
  assign move_skid = (state == FULL) && pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nx;
      in_ready <= (state_nx != FULL);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      EMPTY:   if (accept) state_nx = ONE;
      ONE: begin
        if (accept && !pop)      state_nx = FULL;
        else if (pop && !accept) state_nx = EMPTY;
      end
      FULL:    if (pop) state_nx = ONE;
      default: state_nx = EMPTY;
    endcase
  end

  // Stage p1: main/skid entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_res_p1  <= '0;
      main_zero_p1 <= 1'b0;
      main_ill_p1  <= 1'b0;
      skid_res_p1  <= '0;
      skid_zero_p1 <= 1'b0;
      skid_ill_p1  <= 1'b0;
    end else begin
      if (load_main) begin
        main_res_p1  <= res_p0;
        main_zero_p1 <= zero_p0;
        main_ill_p1  <= ill_p0;
      end else if (move_skid) begin
        main_res_p1  <= skid_res_p1;
        main_zero_p1 <= skid_zero_p1;
        main_ill_p1  <= skid_ill_p1;
      end
      if (load_skid) begin
        skid_res_p1  <= res_p0;
        skid_zero_p1 <= zero_p0;
        skid_ill_p1  <= ill_p0;
      end
    end
  end

  always_comb begin
    out_valid   = (state != EMPTY);
    out_result  = main_res_p1;
    out_zero    = main_zero_p1;
    out_illegal = main_ill_p1;
  end

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: queue-based reference model checked every cycle, plus
// directed vectors with literal expected values.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic [31:0] operand_a, operand_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_illegal;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ill;
  } entry_t;

  entry_t q[$];
  bit     m_acc, m_pop;

  alu_exec #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .operand_a(operand_a), .operand_b(operand_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic entry_t ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    entry_t e;
    e.ill = 1'b0;
    case (op)
      4'd0:    e.res = a & b;
      4'd1:    e.res = a | b;
      4'd2:    e.res = a + b;
      4'd6:    e.res = a - b;
      default: begin e.res = 32'd0; e.ill = 1'b1; end
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  // Reference model: a FIFO of at most two entries
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      m_acc = in_valid && (q.size() < 2);
      m_pop = (q.size() > 0) && out_ready;
      if (m_pop) void'(q.pop_front());
      if (m_acc) q.push_back(ref_op(alu_op, operand_a, operand_b));
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_result", out_result, 0);
      check("rst_out_zero", out_zero, 0);
      check("rst_out_illegal", out_illegal, 0);
    end else begin
      check("model_out_valid", out_valid, q.size() > 0);
      check("model_in_ready", in_ready, q.size() < 2);
      if (q.size() > 0) begin
        check("model_result", out_result, q[0].res);
        check("model_zero", out_zero, q[0].zero);
        check("model_illegal", out_illegal, q[0].ill);
      end
    end
  end

  // One op with out_ready high and the buffer empty; result visible one cycle later
  task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic ez, input logic ei);
    alu_op = op; operand_a = a; operand_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({name, "_valid"}, out_valid, 1);
    check({name, "_result"}, out_result, er);
    check({name, "_zero"}, out_zero, ez);
    check({name, "_illegal"}, out_illegal, ei);
    @(posedge clk); #1;
  endtask

  // Offer an op until accepted, bounded
  task automatic push(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bit rdy;
    bit done;
    done = 1'b0;
    alu_op = op; operand_a = a; operand_b = b; in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) done = 1'b1;
    end
    in_valid = 1'b0;
    if (!done) check("push_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ops [8];
    ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd3, 4'd15, 4'd2, 4'd6};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = 4'd0; operand_a = '0; operand_b = '0;
    repeat (4) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom); out_ready = 1'($urandom);
      alu_op = 4'($urandom); operand_a = $urandom; operand_b = $urandom;
    end
    check("reset_valid", out_valid, 0);
    check("reset_ready", in_ready, 1);
    check("reset_result", out_result, 0);
    in_valid = 1'b0; out_ready = 1'b1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    do_op("add", 4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
    do_op("sub", 4'b0110, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0);
    do_op("and", 4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0);
    do_op("or", 4'b0001, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0);
    do_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
    do_op("sub_wrap", 4'b0110, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op("ill_3", 4'b0011, 32'd3, 32'd4, 32'd0, 1'b1, 1'b1);
    do_op("ill_f", 4'b1111, 32'd3, 32'd4, 32'd0, 1'b1, 1'b1);
    do_op("add_after_ill", 4'b0010, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0);

    // Back-to-back throughput
    alu_op = 4'b0010; operand_b = 32'd1; in_valid = 1'b1;
    operand_a = 32'd10; @(posedge clk); #1;
    operand_a = 32'd20; check("tput_0", out_result, 32'd11);
    @(posedge clk); #1;
    operand_a = 32'd30; check("tput_1", out_result, 32'd21);
    @(posedge clk); #1;
    in_valid = 1'b0; check("tput_2", out_result, 32'd31);
    @(posedge clk); #1;

    // Back-pressure
    out_ready = 1'b0;
    push(4'b0010, 32'd1, 32'd0);
    check("bp_first_result", out_result, 32'd1);
    check("bp_first_ready", in_ready, 1);
    push(4'b0010, 32'd2, 32'd0);
    check("bp_full_ready", in_ready, 0);
    repeat (2) begin @(posedge clk); #1; end
    check("bp_hold_result", out_result, 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_result", out_result, 32'd2);
    check("bp_release_ready", in_ready, 1);
    push(4'b0010, 32'd3, 32'd0);
    push(4'b0010, 32'd4, 32'd0);
    repeat (3) begin @(posedge clk); #1; end

    // Reset while FULL, observed before any clock edge
    out_ready = 1'b0;
    push(4'b1111, 32'd3, 32'd4);
    push(4'b0010, 32'd5, 32'd5);
    check("full_before_rst_ill", out_illegal, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_ready", in_ready, 1);
    check("async_rst_result", out_result, 0);
    check("async_rst_illegal", out_illegal, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Random traffic, checked by the model every cycle
    repeat (10000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      alu_op    = ops[$urandom_range(0, 7)];
      operand_a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      operand_b = ($urandom_range(0, 3) == 0) ? operand_a : $urandom;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
